sobel_frame_capture: RTL and testbench
======================================

Name: sobel_frame_capture

Overview:
Sink at the output end of the Sobel edge-detection stream. Once armed, it accepts the filter's valid-qualified edge-pixel stream and its end-of-frame done pulse, and stores each pixel in raster order into an (IMG_WIDTH-2)x(IMG_HEIGHT-2) frame buffer. It reports frame completion and length errors, and gives the host/checker a random-access read port with one cycle of latency.

Parameters:
WIDTH, 8, pixel bit width
IMG_WIDTH, 256, input image width; output frame width is OUT_W = IMG_WIDTH-2
IMG_HEIGHT, 256, input image height; output frame height is OUT_H = IMG_HEIGHT-2
(derived) DEPTH = OUT_W*OUT_H; must be at most 65535

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
arm  in  1  single-cycle pulse: clear status and begin capturing a frame
pixel_in  in  WIDTH  edge pixel from the filter
valid_in  in  1  pixel_in is valid this cycle (one beat per high cycle)
done_in  in  1  end-of-frame pulse from the filter
rd_en  in  1  read request
rd_row  in  16  read row, 0..OUT_H-1
rd_col  in  16  read column, 0..OUT_W-1
rd_data  out  WIDTH  read data, valid one cycle after rd_en
rd_valid  out  1  registered copy of rd_en
busy  out  1  high while in CAPTURE
frame_ready  out  1  frame ended; held until the next arm or reset
err_short  out  1  sticky: done arrived with fewer than DEPTH beats
err_overrun  out  1  sticky: a beat arrived after DEPTH beats
pix_count  out  17  accepted beats this frame; saturates at DEPTH

Behaviour:
- Reset: state=IDLE; rd_data, rd_valid, busy, frame_ready, err_short, err_overrun, pix_count and the write address all go to 0. Frame buffer contents are not reset. Reset mid-capture aborts the frame; there is no partial-frame status.
- States: IDLE, CAPTURE, READY.
- IDLE: valid_in and done_in are ignored. arm -> CAPTURE next cycle.
- Any state, arm: next cycle state=CAPTURE, write address=0, pix_count=0, errors=0, frame_ready=0. arm takes priority over valid_in and done_in in the same cycle; those are dropped.
- CAPTURE beat (valid_in=1):
  - If pix_count < DEPTH: write pixel_in to address wr_addr, then wr_addr+1 and pix_count+1.
  - Otherwise: no write, and err_overrun=1.
  - Gaps between beats of any length are allowed.
- CAPTURE done_in:
  - Next cycle: state=READY, frame_ready=1, busy=0.
  - err_short=1 if the post-update count is below DEPTH.
  - A beat in the same cycle as done_in is accepted first and counted.
- READY: valid_in is ignored and does not set err_overrun. done_in is ignored.
- busy is a registered flag equal to (state==CAPTURE).
- Address: linear, row-major. addr = row*OUT_W + col (17-bit intermediate). The write side uses an incrementing counter; the read side computes the multiply.
- Read: registered, 1-cycle latency, allowed in every state.
  - Out-of-range row or column returns rd_data=0 with rd_valid=1.
  - Same-address read and write in one cycle returns the old data (read-first).
  - When rd_en=0, rd_data holds its last value.

Decomposition:
- Shared package sobel_pkg: state encoding (IDLE/CAPTURE/READY) and the out_dim helper (dimension minus 2).
- The WIDTH/IMG_* defaults stay module parameters, not package constants.
- One sub-module: sobel_capture_ram, a simple dual-port synchronous RAM with one write port and one registered read-first read port; depth and width are parameters.
- The FSM, counters and address multiply stay in the top module.

Test Plan:
(All cases except 5 use IMG_WIDTH=6, IMG_HEIGHT=5, so OUT_W=4, OUT_H=3, DEPTH=12.)
1. Reset, drive valid_in=1 without arm, release reset -> all outputs 0. After 3 beats, pix_count stays 0 and busy stays 0.
2. arm; 12 contiguous beats with values 1..12; done_in one cycle after the last beat -> frame_ready=1 the cycle after done_in, pix_count=12, both errors 0. Read (1,2) -> rd_data=7 one cycle later. Read (2,3) -> 12.
3. Same frame with valid_in high every third cycle, and done_in in the same cycle as beat 12 -> identical status and contents. Read (0,0) -> 1.
4. arm; 10 beats; done_in -> frame_ready=1, err_short=1, pix_count=10. Read (2,1) -> 10.
5. IMG_WIDTH=6, IMG_HEIGHT=5; arm; 14 beats with values 1..14 -> err_overrun=1 on the beat-13 cycle +1, pix_count=12. After done_in, read (2,3) -> 12 (not overwritten). Read (3,0) and read (0,4) -> rd_data=0, rd_valid=1.
6. arm; 5 beats; assert rst -> all outputs 0 immediately. Release reset, arm, and run a full 12-beat frame -> pix_count=12, frame_ready=1. Then arm again in READY -> frame_ready=0, busy=1, pix_count=0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel frame capture sink.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  // A 3x3 kernel without padding trims one pixel from every edge.
  function automatic int out_dim(input int dim);
    return dim - 2;
  endfunction

endpackage

// File: rtl/sobel_capture_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module sobel_capture_ram #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Separate non-blocking read sees the pre-write contents on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_frame_capture.sv
// Captures one Sobel output frame into a buffer and exposes a 1-cycle read port.
//   state      | meaning
//   ST_IDLE    | waiting for arm, stream ignored
//   ST_CAPTURE | storing beats in raster order until done_in
//   ST_READY   | frame ended, status held until next arm
module sobel_frame_capture
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [WIDTH-1:0] pixel_in,
  input  logic             valid_in,
  input  logic             done_in,
  input  logic             rd_en,
  input  logic [15:0]      rd_row,
  input  logic [15:0]      rd_col,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             frame_ready,
  output logic             err_short,
  output logic             err_overrun,
  output logic [16:0]      pix_count
);

  localparam int OUT_W = out_dim(IMG_WIDTH);
  localparam int OUT_H = out_dim(IMG_HEIGHT);
  localparam int DEPTH = OUT_W * OUT_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_C = 17'(DEPTH);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_busy;
  logic             r_frame_ready;
  logic             r_err_short;
  logic             r_err_overrun;
  logic             r_rd_valid;
  logic             r_rd_oob;
  logic [16:0]      r_pix_count;
  logic [16:0]      w_pix_post;
  logic [AW-1:0]    r_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic             w_in_capture;
  logic             w_wr_en;
  logic             w_set_overrun;
  logic             w_frame_end;
  logic             w_rd_in_range;
  logic             w_ram_re;
  logic [WIDTH-1:0] w_ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_CAPTURE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (arm) begin
      w_next_state = ST_CAPTURE;
    end else begin
      case (r_state)
        ST_CAPTURE: if (done_in) w_next_state = ST_READY;
        default:    w_next_state = r_state;
      endcase
    end
  end

  // arm in the same cycle drops any beat or done.
  always_comb begin
    w_in_capture  = (r_state == ST_CAPTURE) && !arm;
    w_wr_en       = w_in_capture && valid_in && (r_pix_count < DEPTH_C);
    w_set_overrun = w_in_capture && valid_in && (r_pix_count >= DEPTH_C);
    w_frame_end   = w_in_capture && done_in;
    w_pix_post    = r_pix_count + {16'd0, w_wr_en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr     <= '0;
      r_pix_count   <= '0;
      r_frame_ready <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else if (arm) begin
      r_wr_addr     <= '0;
      r_pix_count   <= '0;
      r_frame_ready <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_addr   <= r_wr_addr + AW'(1);
        r_pix_count <= w_pix_post;
      end
      if (w_set_overrun) r_err_overrun <= 1'b1;
      if (w_frame_end) begin
        r_frame_ready <= 1'b1;
        if (w_pix_post < DEPTH_C) r_err_short <= 1'b1;
      end
    end
  end

  assign w_rd_in_range = (rd_row < 16'(OUT_H)) && (rd_col < 16'(OUT_W));
  assign w_rd_addr     = AW'(17'(rd_row) * 17'(OUT_W) + 17'(rd_col));
  assign w_ram_re      = rd_en && w_rd_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_oob <= !w_rd_in_range;
    end
  end

  sobel_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (pixel_in),
    .i_re    (w_ram_re),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  // Out-of-range reads never touch the RAM; the flag forces zero instead.
  assign rd_data     = r_rd_oob ? '0 : w_ram_rdata;
  assign rd_valid    = r_rd_valid;
  assign busy        = r_busy;
  assign frame_ready = r_frame_ready;
  assign err_short   = r_err_short;
  assign err_overrun = r_err_overrun;
  assign pix_count   = r_pix_count;

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Directed bench for sobel_frame_capture on a 6x5 image (4x3 output frame).
module tb_sobel_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        valid_in = 1'b0;
  logic        done_in = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_row = '0;
  logic [15:0] rd_col = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        frame_ready;
  logic        err_short;
  logic        err_overrun;
  logic [16:0] pix_count;

  int n_tests = 0;
  int n_fail  = 0;

  sobel_frame_capture #(
    .WIDTH      (8),
    .IMG_WIDTH  (6),
    .IMG_HEIGHT (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .done_in     (done_in),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .frame_ready (frame_ready),
    .err_short   (err_short),
    .err_overrun (err_overrun),
    .pix_count   (pix_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_beats(input int first, input int n, input int period, input bit done_last);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      pixel_in = 8'(first + i);
      if (done_last && i == n - 1) done_in = 1'b1;
      tick();
      valid_in = 1'b0;
      done_in  = 1'b0;
      for (int g = 1; g < period; g++) tick();
    end
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic do_read(input int row, input int col);
    rd_row = 16'(row);
    rd_col = 16'(col);
    rd_en  = 1'b1;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b1;
    pixel_in = 8'hAA;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({rd_data, rd_valid, busy, frame_ready, err_short, err_overrun, pix_count} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%0d vld=%0b busy=%0b rdy=%0b es=%0b eo=%0b cnt=%0d want all 0",
               rd_data, rd_valid, busy, frame_ready, err_short, err_overrun, pix_count);
    end
    tick(); tick(); tick();
    valid_in = 1'b0;
    n_tests++;
    if (pix_count !== 17'd0) begin
      n_fail++; $display("FAIL idle_ignores_valid_count: got %0d want 0", pix_count);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_contiguous();
    do_arm();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL arm_busy: got %0b want 1", busy);
    end
    send_beats(1, 12, 1, 1'b0);
    n_tests++;
    if (frame_ready !== 1'b0 || pix_count !== 17'd12) begin
      n_fail++; $display("FAIL pre_done: got rdy=%0b cnt=%0d want rdy=0 cnt=12", frame_ready, pix_count);
    end
    pulse_done();
    n_tests++;
    if (frame_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL contig_done: got rdy=%0b busy=%0b want 1 0", frame_ready, busy);
    end
    n_tests++;
    if (pix_count !== 17'd12 || err_short !== 1'b0 || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL contig_status: got cnt=%0d es=%0b eo=%0b want 12 0 0", pix_count, err_short, err_overrun);
    end
    do_read(1, 2);
    n_tests++;
    if (rd_data !== 8'd7 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL contig_read_1_2: got %0d vld=%0b want 7 1", rd_data, rd_valid);
    end
    tick();
    n_tests++;
    if (rd_data !== 8'd7 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_hold: got %0d vld=%0b want 7 0", rd_data, rd_valid);
    end
    do_read(2, 3);
    n_tests++;
    if (rd_data !== 8'd12) begin
      n_fail++; $display("FAIL contig_read_2_3: got %0d want 12", rd_data);
    end
  endtask

  task automatic test_gapped();
    do_arm();
    send_beats(1, 12, 3, 1'b1);
    n_tests++;
    if (frame_ready !== 1'b1 || busy !== 1'b0 || pix_count !== 17'd12) begin
      n_fail++; $display("FAIL gapped_status: got rdy=%0b busy=%0b cnt=%0d want 1 0 12", frame_ready, busy, pix_count);
    end
    n_tests++;
    if (err_short !== 1'b0 || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL gapped_errors: got es=%0b eo=%0b want 0 0", err_short, err_overrun);
    end
    do_read(0, 0);
    n_tests++;
    if (rd_data !== 8'd1) begin
      n_fail++; $display("FAIL gapped_read_0_0: got %0d want 1", rd_data);
    end
    do_read(1, 2);
    n_tests++;
    if (rd_data !== 8'd7) begin
      n_fail++; $display("FAIL gapped_read_1_2: got %0d want 7", rd_data);
    end
  endtask

  task automatic test_short();
    do_arm();
    send_beats(1, 10, 1, 1'b0);
    pulse_done();
    n_tests++;
    if (frame_ready !== 1'b1 || err_short !== 1'b1 || pix_count !== 17'd10 || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL short_status: got rdy=%0b es=%0b cnt=%0d eo=%0b want 1 1 10 0",
                         frame_ready, err_short, pix_count, err_overrun);
    end
    do_read(2, 1);
    n_tests++;
    if (rd_data !== 8'd10) begin
      n_fail++; $display("FAIL short_read_2_1: got %0d want 10", rd_data);
    end
    valid_in = 1'b1;
    pixel_in = 8'h55;
    tick(); tick();
    valid_in = 1'b0;
    n_tests++;
    if (err_overrun !== 1'b0 || pix_count !== 17'd10) begin
      n_fail++; $display("FAIL ready_ignores_valid: got eo=%0b cnt=%0d want 0 10", err_overrun, pix_count);
    end
  endtask

  task automatic test_overrun();
    do_arm();
    send_beats(1, 12, 1, 1'b0);
    n_tests++;
    if (err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_early: got %0b want 0", err_overrun);
    end
    send_beats(13, 1, 1, 1'b0);
    n_tests++;
    if (err_overrun !== 1'b1 || pix_count !== 17'd12) begin
      n_fail++; $display("FAIL overrun_beat13: got eo=%0b cnt=%0d want 1 12", err_overrun, pix_count);
    end
    send_beats(14, 1, 1, 1'b0);
    pulse_done();
    n_tests++;
    if (frame_ready !== 1'b1 || err_short !== 1'b0 || err_overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_done: got rdy=%0b es=%0b eo=%0b want 1 0 1", frame_ready, err_short, err_overrun);
    end
    do_read(2, 3);
    n_tests++;
    if (rd_data !== 8'd12) begin
      n_fail++; $display("FAIL overrun_no_overwrite: got %0d want 12", rd_data);
    end
    do_read(3, 0);
    n_tests++;
    if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL oob_row: got %0d vld=%0b want 0 1", rd_data, rd_valid);
    end
    do_read(2, 2);
    n_tests++;
    if (rd_data !== 8'd11) begin
      n_fail++; $display("FAIL read_after_oob: got %0d want 11", rd_data);
    end
    do_read(0, 4);
    n_tests++;
    if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL oob_col: got %0d vld=%0b want 0 1", rd_data, rd_valid);
    end
  endtask

  task automatic test_rst_abort();
    do_arm();
    send_beats(1, 5, 1, 1'b0);
    n_tests++;
    if (busy !== 1'b1 || pix_count !== 17'd5) begin
      n_fail++; $display("FAIL pre_abort: got busy=%0b cnt=%0d want 1 5", busy, pix_count);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rd_data, rd_valid, busy, frame_ready, err_short, err_overrun, pix_count} !== 30'd0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%0d vld=%0b busy=%0b rdy=%0b es=%0b eo=%0b cnt=%0d want all 0",
               rd_data, rd_valid, busy, frame_ready, err_short, err_overrun, pix_count);
    end
    tick();
    rst = 1'b0;
    do_arm();
    // First beat writes address 0 while reading it: old value (1) expected.
    valid_in = 1'b1;
    pixel_in = 8'd21;
    rd_row = 16'd0;
    rd_col = 16'd0;
    rd_en  = 1'b1;
    tick();
    valid_in = 1'b0;
    rd_en    = 1'b0;
    n_tests++;
    if (rd_data !== 8'd1) begin
      n_fail++; $display("FAIL read_first: got %0d want 1", rd_data);
    end
    send_beats(22, 11, 1, 1'b0);
    pulse_done();
    n_tests++;
    if (pix_count !== 17'd12 || frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_frame: got cnt=%0d rdy=%0b want 12 1", pix_count, frame_ready);
    end
    do_read(0, 0);
    n_tests++;
    if (rd_data !== 8'd21) begin
      n_fail++; $display("FAIL post_reset_read_0_0: got %0d want 21", rd_data);
    end
    do_arm();
    n_tests++;
    if (frame_ready !== 1'b0 || busy !== 1'b1 || pix_count !== 17'd0) begin
      n_fail++; $display("FAIL rearm_in_ready: got rdy=%0b busy=%0b cnt=%0d want 0 1 0", frame_ready, busy, pix_count);
    end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gapped();
    test_short();
    test_overrun();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
